// File: rtl/count_wrap_monitor.sv
// Checks the step sequence of an up/down counter, flags wrap events and
// tracks net revolutions. Optional macro COUNT_WRAP_MONITOR_HOLD_ALLOW_EN accepts delta == 0 as a hold.
//
// state | meaning
// SYNC  | capture first sample after reset/clear, no checking
// RUN   | check each step, report wraps and errors
// FAULT | sticky after ERR_LIMIT consecutive illegal steps
module count_wrap_monitor #(
    parameter int WIDTH     = 5,
    parameter int REV_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_fault,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             step_err,
    output logic [REV_W-1:0] rev_cnt,
    output logic             fault,
    output logic [1:0]       state
);

    localparam logic [1:0]       SYNC     = 2'd0;
    localparam logic [1:0]       RUN      = 2'd1;
    localparam logic [1:0]       FAULT    = 2'd2;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [REV_W-1:0] REV_ONE  = REV_W'(1);
    localparam logic [3:0]       ERR_MAX  = 4'(ERR_LIMIT);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] prev_q;
    logic             mode_q;
    logic [3:0]       err_run;
    logic [WIDTH-1:0] delta;
    logic             legal;
    logic             hold;
    logic             up_wrap;
    logic             down_wrap;

    assign delta     = din - prev_q;
    assign legal     = mode_q ? (delta == ONE) : (delta == ALL_ONES);
    assign up_wrap   = mode_q && (prev_q == ALL_ONES) && (din == '0);
    assign down_wrap = !mode_q && (prev_q == '0) && (din == ALL_ONES);
`ifdef COUNT_WRAP_MONITOR_HOLD_ALLOW_EN
    assign hold      = (delta == '0);
`else
    assign hold      = 1'b0;
`endif

    assign fault = (state_q == FAULT);
    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SYNC;
            prev_q    <= '0;
            mode_q    <= 1'b0;
            err_run   <= '0;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            step_err  <= 1'b0;
            rev_cnt   <= '0;
        end else begin
            prev_q    <= din;
            mode_q    <= mode;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            step_err  <= 1'b0;
            case (state_q)
                SYNC: begin
                    state_q <= RUN;
                    if (clr_fault) err_run <= '0;
                end
                RUN: begin
                    if (hold) begin
                        if (clr_fault) err_run <= '0;
                    end else if (legal) begin
                        err_run   <= '0;
                        wrap_up   <= up_wrap;
                        wrap_down <= down_wrap;
                        if (up_wrap)
                            rev_cnt <= rev_cnt + REV_ONE;
                        else if (down_wrap)
                            rev_cnt <= rev_cnt - REV_ONE;
                    end else begin
                        step_err <= 1'b1;
                        // a coincident clear wins over escalation to FAULT
                        if (clr_fault) begin
                            err_run <= '0;
                        end else if (err_run >= ERR_MAX - 4'd1) begin
                            err_run <= ERR_MAX;
                            state_q <= FAULT;
                        end else begin
                            err_run <= err_run + 4'd1;
                        end
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_q <= SYNC;
                        err_run <= '0;
                    end
                end
                default: begin
                    state_q <= SYNC;
                    err_run <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: directed scenarios with literal expectations,
// then randomized traffic against a step/wrap reference model.
module tb_count_wrap_monitor;

    localparam int LIM = 3;
`ifdef COUNT_WRAP_MONITOR_HOLD_ALLOW_EN
    localparam bit HOLD_OK = 1'b1;
`else
    localparam bit HOLD_OK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [4:0] din;
    logic       clr_fault;
    logic       wrap_up, wrap_down, step_err, fault;
    logic [7:0] rev_cnt;
    logic [1:0] state;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    int m_state, m_prev, m_mode, m_err, m_rev;
    bit e_wu, e_wd, e_se;
    int wu_seen = 0, wd_seen = 0, se_seen = 0;

    always #5 clk = ~clk;

    count_wrap_monitor #(.WIDTH(5), .REV_W(8), .ERR_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset), .mode(mode), .din(din), .clr_fault(clr_fault),
        .wrap_up(wrap_up), .wrap_down(wrap_down), .step_err(step_err),
        .rev_cnt(rev_cnt), .fault(fault), .state(state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_mode = 0; m_err = 0; m_rev = 0;
        e_wu = 0; e_wd = 0; e_se = 0;
    endtask

    // Reference: the counter should land on prev +/- 1; leaving 0..31 on a legal move is a wrap.
    task automatic model_step(input int d, input int m, input int c);
        int target;
        e_wu = 0; e_wd = 0; e_se = 0;
        if (m_state == 0) begin
            m_state = 1;
            if (c != 0) m_err = 0;
        end else if (m_state == 1) begin
            target = m_prev + (m_mode != 0 ? 1 : -1);
            if (HOLD_OK && d == m_prev) begin
                if (c != 0) m_err = 0;
            end else if (((target + 32) % 32) == d) begin
                m_err = 0;
                if (target == 32) begin e_wu = 1; m_rev = (m_rev + 1) % 256; end
                if (target == -1) begin e_wd = 1; m_rev = (m_rev + 255) % 256; end
            end else begin
                e_se = 1;
                if (c != 0) m_err = 0;
                else begin
                    m_err = m_err + 1;
                    if (m_err >= LIM) begin m_err = LIM; m_state = 2; end
                end
            end
        end else if (c != 0) begin
            m_state = 0;
            m_err = 0;
        end
        m_prev = d;
        m_mode = m;
    endtask

    task automatic cycle(input int d, input int m, input int c);
        din = 5'(d % 32);
        mode = (m != 0);
        clr_fault = (c != 0);
        @(posedge clk);
        if (reset) model_step(d % 32, (m != 0) ? 1 : 0, c);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("wrap_up", wrap_up, e_wu);
            check("wrap_down", wrap_down, e_wd);
            check("step_err", step_err, e_se);
            check("rev_cnt", rev_cnt, m_rev);
            check("fault", fault, (m_state == 2));
            check("state", state, m_state);
            if (wrap_up) wu_seen++;
            if (wrap_down) wd_seen++;
            if (step_err) se_seen++;
        end
    end

    initial begin
        int cur, mm, r, c;
        reset = 1'b0; din = '0; mode = 1'b0; clr_fault = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", state, 0);
        check("reset_rev", rev_cnt, 0);
        check("reset_pulses", {wrap_up, wrap_down, step_err, fault}, 0);
        reset = 1'b1;
        check_en = 1'b1;

        // count up through one full wrap
        for (int v = 0; v <= 33; v++) cycle(v, 1, 0);
        check("seq1_rev", rev_cnt, 1);
        check("seq1_wu_pulses", wu_seen, 1);
        check("seq1_no_err", se_seen, 0);
        check("seq1_state", state, 1);

        // turn around at 3 and count down through zero
        cycle(2, 1, 0); cycle(3, 0, 0);
        cycle(2, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(31, 0, 0); cycle(30, 0, 0);
        check("seq2_rev", rev_cnt, 0);
        check("seq2_wd_pulses", wd_seen, 1);
        check("seq2_no_err", se_seen, 0);

        // 30->29 legal down, 29->5 illegal, 5->6 legal, then three illegal -> FAULT
        cycle(29, 1, 0);
        cycle(5, 1, 0); cycle(6, 1, 0); cycle(9, 1, 0); cycle(12, 1, 0); cycle(15, 1, 0);
        check("seq3_err_pulses", se_seen, 4);
        check("seq3_fault", fault, 1);
        check("seq3_state", state, 2);
        cycle(16, 1, 0); cycle(17, 1, 0);
        check("seq3_frozen_err", se_seen, 4);
        check("seq3_frozen_rev", rev_cnt, 0);

        cycle(18, 1, 1);
        check("clr_state_sync", state, 0);
        check("clr_fault_low", fault, 0);
        cycle(19, 1, 0);
        check("clr_state_run", state, 1);
        check("clr_rev_kept", rev_cnt, 0);

        // two illegal, one legal, two illegal: never reaches the limit
        cycle(25, 1, 0); cycle(27, 1, 0); cycle(28, 1, 0); cycle(2, 1, 0); cycle(9, 1, 0);
        check("seq5_err_pulses", se_seen, 8);
        check("seq5_no_fault", fault, 0);

        // settle at 7 with mode up, then hold for three cycles
        cycle(10, 0, 0); cycle(9, 0, 0); cycle(8, 0, 0); cycle(7, 1, 0);
        cycle(7, 1, 0); cycle(7, 1, 0); cycle(7, 1, 0);
        check("hold_err_pulses", se_seen, HOLD_OK ? 8 : 11);
        check("hold_state", state, HOLD_OK ? 1 : 2);

        cycle(7, 1, 1); cycle(7, 1, 0);
        for (int k = 8; k <= 64; k++) cycle(k, 1, 0);
        check("rev_two", rev_cnt, 2);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rev", rev_cnt, 0);
        check("async_state", state, 0);
        check("async_outs", {wrap_up, wrap_down, step_err, fault}, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        cur = 0; mm = 1;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) cur = (cur + (mm != 0 ? 1 : 31)) % 32;
            else if (r >= 82) cur = $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) mm = 1 - mm;
            c = (m_state != 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
            cycle(cur, mm, c);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Downstream checker for the 5-bit up/down counter. Consumes the counter's `dout` and `mode` every clock.
- Verifies each step is a legal ±1 move for the active direction.
- Reports up/down wrap-around events and keeps a net revolution count.
- Enters a sticky FAULT state after repeated illegal steps, for use by downstream display/alarm logic.

Parameters:
- WIDTH, 5, width of monitored count input.
- REV_W, 8, width of net revolution counter.
- ERR_LIMIT, 3, consecutive illegal steps required to enter FAULT (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  counter direction (1 = up, 0 = down), same signal that drives the counter.
- din  input  WIDTH  counter output `dout`.
- clr_fault  input  1  synchronous fault clear; single-cycle pulse.
- wrap_up  output  1  one-cycle pulse on an up wrap (all-ones -> 0).
- wrap_down  output  1  one-cycle pulse on a down wrap (0 -> all-ones).
- step_err  output  1  one-cycle pulse on an illegal step.
- rev_cnt  output  REV_W  net revolutions: +1 per up wrap, -1 per down wrap, modulo 2^REV_W.
- fault  output  1  high while in FAULT.
- state  output  2  encoded state: SYNC = 0, RUN = 1, FAULT = 2.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = SYNC; prev_q = 0; mode_q = 0; err_run = 0.
  - All outputs 0, rev_cnt = 0.
- Every rising edge: prev_q <= din; mode_q <= mode. Comparisons always use the previous sample's mode (mode_q), because that mode produced the step.
- Step check: delta = (din - prev_q) mod 2^WIDTH.
  - Legal step: delta == 1 when mode_q = 1; delta == 2^WIDTH-1 when mode_q = 0.
  - Anything else is illegal, including delta == 0 (see the optional feature).
- SYNC:
  - First edge after reset release captures prev_q/mode_q only. No check, no pulses.
  - Goes to RUN on the next edge.
- RUN, legal step:
  - err_run <= 0.
  - wrap_up = 1 next cycle if mode_q = 1, prev_q = all-ones, din = 0; rev_cnt increments.
  - wrap_down = 1 next cycle if mode_q = 0, prev_q = 0, din = all-ones; rev_cnt decrements.
- RUN, illegal step:
  - step_err = 1 next cycle; err_run saturates at ERR_LIMIT.
  - When err_run reaches ERR_LIMIT, state -> FAULT in the same update.
  - No wrap pulse and no rev_cnt change on an illegal step.
- FAULT:
  - fault = 1. step_err, wrap_up and wrap_down are held 0; rev_cnt is frozen.
  - prev_q/mode_q keep tracking.
  - clr_fault = 1 -> SYNC with err_run = 0. rev_cnt is retained; only reset clears it.
- clr_fault in SYNC or RUN: clears err_run only; no state change.
- Latency: every pulse output is registered and asserts exactly one cycle after the edge that sampled the offending or wrapping din.
- Direction change (mode toggles): no special case. The first step after the toggle is checked against the new mode_q.
- Reset mid-operation: immediate return to reset values regardless of state. Counter and monitor resynchronize via SYNC.
- Simultaneous wrap_up and wrap_down cannot occur; at most one of step_err, wrap_up or wrap_down per cycle.

Optional Feature:
- Macro: COUNT_WRAP_MONITOR_HOLD_ALLOW_EN.
- Defined: delta == 0 is a legal hold. No step_err, err_run unchanged, no wrap. Supports a counter with an enable.
- Undefined: delta == 0 is an illegal step as above.

Test Plan:
- Reset low 2 cycles, release, mode = 1, drive din 0,1,2,...,31,0,1 -> no step_err; wrap_up single pulse one cycle after din 31->0 sample; rev_cnt = 1; state SYNC -> RUN.
- From RUN at din = 3, mode = 0, drive 2,1,0,31,30 -> wrap_down single pulse after 0->31; rev_cnt decrements to 0; no step_err.
- Mode = 1, din 5,6,9,12,15 -> step_err pulses on the 6->9, 9->12 and 12->15 steps; third error sets fault = 1, state = 2; subsequent legal steps 16,17 produce no pulses and rev_cnt is frozen.
- In FAULT, pulse clr_fault one cycle -> state = 0 (SYNC) then 1 (RUN); fault = 0; rev_cnt unchanged.
- Two illegal steps, then one legal step, then two illegal steps (ERR_LIMIT = 3) -> four step_err pulses, fault stays 0.
- Assert reset = 0 mid-run with rev_cnt = 2 -> all outputs 0 immediately without waiting for clk.
- Hold din at 7 for 3 cycles with mode = 1 -> macro undefined: step_err pulses and FAULT entered; macro defined: no step_err, state stays RUN.
